// File: rtl/std_sram_ctrl_pkg.sv
// Shared types and constants for the single-port SRAM valid/ready controller.
package std_sram_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_t;

    localparam int unsigned RSP_DEPTH = 2;
    localparam int unsigned RSP_CNT_W = $clog2(RSP_DEPTH + 1);

endpackage

// File: rtl/std_sram_rsp_buffer.sv
// Two-entry registered response FIFO; head is the oldest buffered read word.
module std_sram_rsp_buffer
    import std_sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [RSP_CNT_W-1:0]  count,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every observation of it.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/std_sram_singleport_ctrl.sv
// Valid/ready front-end for the latched single-port SRAM with credit-limited read responses.
// Define STD_SRAM_CTRL_INIT_EN to sweep INIT_VALUE into every address after reset.
module std_sram_singleport_ctrl
    import std_sram_ctrl_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH = 6,
    parameter int unsigned          DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    ctrl_state_t            state;
    ctrl_state_t            next_state;
    logic                   inflight;
    logic                   pop;
    logic                   rd_issue;
    logic [RSP_CNT_W-1:0]   rsp_count;
    logic [RSP_CNT_W:0]     credit_used;

`ifdef STD_SRAM_CTRL_INIT_EN
    localparam logic [ADDR_WIDTH-1:0] SWEEP_LAST = '1;
    logic [ADDR_WIDTH-1:0] sweep_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_INIT;
        else         state <= next_state;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)               sweep_cnt <= '0;
        else if (state == ST_INIT) sweep_cnt <= sweep_cnt + 1'b1;
    end

    assign init_done = (state == ST_RUN);
`else
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_RUN;
        else         state <= next_state;
    end

    assign init_done = 1'b1;
`endif

    assign rsp_valid = (rsp_count != '0);
    assign pop       = rsp_valid & rsp_ready;

    // Slots already claimed: buffered + in flight, less the one leaving this cycle.
    assign credit_used = {1'b0, rsp_count} + (RSP_CNT_W + 1)'(inflight) - (RSP_CNT_W + 1)'(pop);

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = req_addr;
        sram_din   = INIT_VALUE;
        case (state)
`ifdef STD_SRAM_CTRL_INIT_EN
            ST_INIT: begin
                sram_en   = resetn;
                sram_we   = 1'b1;
                sram_addr = sweep_cnt;
                if (sweep_cnt == SWEEP_LAST) next_state = ST_RUN;
            end
`endif
            ST_RUN: begin
                req_ready = resetn & (credit_used < (RSP_CNT_W + 1)'(RSP_DEPTH));
                sram_en   = req_valid & req_ready;
                sram_we   = req_we;
                sram_din  = req_wdata;
            end
            default: ;
        endcase
    end

    assign rd_issue = sram_en & ~sram_we;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) inflight <= 1'b0;
        else         inflight <= rd_issue;
    end

    std_sram_rsp_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_buffer (
        .clk       (clk),
        .resetn    (resetn),
        .push      (inflight),
        .push_data (sram_dout),
        .pop       (pop),
        .count     (rsp_count),
        .head      (rsp_rdata)
    );

endmodule

// File: tb/tb_std_sram_singleport_ctrl.sv
// Scoreboard bench for std_sram_singleport_ctrl with a behavioural latched-SRAM and memory model.
// Honours STD_SRAM_CTRL_INIT_EN to check the post-reset sweep as well.
module tb_std_sram_singleport_ctrl;

    localparam int unsigned AW    = 3;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [DW-1:0] IV  = 32'hA5A5A5A5;

    logic          clk;
    logic          resetn;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;

    std_sram_singleport_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INIT_VALUE (IV)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .sram_en   (sram_en),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latched single-port SRAM: dout only changes on a read.
    logic [DW-1:0] sram_mem [DEPTH];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) sram_mem[sram_addr] <= sram_din;
            else         sram_dout <= sram_mem[sram_addr];
        end
    end

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int total;
    int bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted request in order against a plain array.
    always @(negedge clk) begin
        if (resetn && req_valid && req_ready) begin
            if (req_we) ref_mem[req_addr] = req_wdata;
            else        exp_q.push_back(ref_mem[req_addr]);
        end
    end

    always @(negedge clk) begin
        if (resetn && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) check("rsp_unexpected", 64'(rsp_rdata), 64'hDEAD_0000_0000_0000);
            else                   check("rsp_data", 64'(rsp_rdata), 64'(exp_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic after_reset();
`ifdef STD_SRAM_CTRL_INIT_EN
        for (int k = 0; k < int'(DEPTH); k++) begin
            @(negedge clk);
            check("sweep_en", 64'(sram_en & sram_we), 64'd1);
            check("sweep_addr", 64'(sram_addr), 64'(k));
            check("sweep_din", 64'(sram_din), 64'(IV));
            check("sweep_busy", 64'({init_done, req_ready}), 64'd0);
        end
        @(negedge clk);
        check("init_done_rise", 64'({init_done, req_ready}), 64'd3);
`else
        @(negedge clk);
        check("init_done_first", 64'({init_done, req_ready}), 64'd3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("idle_no_en", 64'(sram_en), 64'd0);
        end
`endif
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        exp_q.delete();
`ifdef STD_SRAM_CTRL_INIT_EN
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = IV;
`endif
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_sram_en", 64'(sram_en), 64'd0);
`ifdef STD_SRAM_CTRL_INIT_EN
        check("rst_init_done", 64'(init_done), 64'd0);
`else
        check("rst_init_done", 64'(init_done), 64'd1);
`endif
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        after_reset();
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while ((exp_q.size() != 0 || rsp_valid) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] held;
        int n;
        total = 0;
        bad   = 0;
        resetn    = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            sram_mem[i] = $urandom;
`ifdef STD_SRAM_CTRL_INIT_EN
            ref_mem[i] = IV;
`else
            ref_mem[i] = sram_mem[i];
`endif
        end
        step();
        do_reset();

`ifdef STD_SRAM_CTRL_INIT_EN
        step();
        drive(1'b1, 1'b0, 3'd5, '0);
        step();
        drive(1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        check("init_read5", 64'(rsp_rdata), 64'(IV));
`endif

        // Write then read the same address on the next cycle.
        step();
        drive(1'b1, 1'b1, 3'd3, 32'h1234_5678);
        step();
        drive(1'b1, 1'b0, 3'd3, '0);
        step();
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("lat_n2_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("lat_n3_valid", 64'(rsp_valid), 64'd1);
        check("lat_n3_data", 64'(rsp_rdata), 64'h1234_5678);
        wait_drain(10);

        // Back-to-back reads at full rate.
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1'b1, 1'b0, AW'(i), '0);
            @(negedge clk);
            check("b2b_ready", 64'(req_ready), 64'd1);
            if (i >= 2) check("b2b_valid", 64'(rsp_valid), 64'd1);
        end
        step();
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("b2b_valid4", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        check("b2b_valid5", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        check("b2b_valid6", 64'(rsp_valid), 64'd0);

        // Backpressure: two credits, then stall.
        step();
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 3'd4, '0);
        @(negedge clk);
        check("bp_ready0", 64'(req_ready), 64'd1);
        step();
        drive(1'b1, 1'b0, 3'd5, '0);
        @(negedge clk);
        check("bp_ready1", 64'(req_ready), 64'd1);
        step();
        drive(1'b1, 1'b0, 3'd6, '0);
        @(negedge clk);
        check("bp_ready2", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("bp_ready3", 64'(req_ready), 64'd0);
        check("bp_full_valid", 64'(rsp_valid), 64'd1);
        held = rsp_rdata;
        repeat (2) @(negedge clk);
        check("bp_hold", 64'(rsp_rdata), 64'(held));
        step();
        rsp_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("bp_third_accept", 64'(req_ready), 64'd1);
        step();
        drive(1'b0, 1'b0, '0, '0);
        wait_drain(20);

        // Reset with one response buffered and one read in flight.
        step();
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 3'd1, '0);
        step();
        drive(1'b1, 1'b0, 3'd2, '0);
        step();
        drive(1'b0, 1'b0, '0, '0);
        #2;
        do_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_quiet", 64'(rsp_valid), 64'd0);
        end

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            step();
            drive($urandom_range(99) < 60, $urandom_range(99) < 40, AW'($urandom), $urandom);
            rsp_ready = $urandom_range(99) < 70;
        end
        step();
        drive(1'b0, 1'b0, '0, '0);
        wait_drain(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
